// File: rtl/custom_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : custom_adder_pipe
// Description : SIZE-bit adder with carry-in/carry-out built from 4-bit
//               carry-lookahead groups with rippled group carries. The sum,
//               the carry-out and a valid flag are registered (one-cycle
//               latency, one operation per cycle, no stall).
// Revision    : 1.0 - initial release
// ============================================================================
module custom_adder_pipe #(
  parameter int SIZE = 32  // operand/result width, legal range 1..64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            Cin,
  output logic [SIZE-1:0] Result,
  output logic            Cout,
  output logic            out_valid
);

  // Number of 4-bit lookahead groups; the top one is partial when SIZE is
  // not a multiple of 4.
  localparam int GROUP_W = 4;
  localparam int NGROUPS = (SIZE + GROUP_W - 1) / GROUP_W;

  // Per-bit generate/propagate and the combinational sum.
  logic [SIZE-1:0] bit_gen;
  logic [SIZE-1:0] bit_prop;
  logic [SIZE-1:0] sum_comb;
  logic            carry_out;

  assign bit_gen  = A & B;
  assign bit_prop = A ^ B;

  // Two-level lookahead carry out of the low n bits of a group:
  //   c_n = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0] | p[n-1..0]c0
  // Written as a flat sum of products so each carry is independent of the
  // other carries inside the group.
  function automatic logic lookahead(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       c0,
    input int         n
  );
    logic c;
    logic pp;
    c = 1'b0;
    for (int k = 0; k < n; k++) begin
      pp = 1'b1;
      for (int m = k + 1; m < n; m++) begin
        pp = pp & p[m];
      end
      c = c | (g[k] & pp);
    end
    pp = 1'b1;
    for (int m = 0; m < n; m++) begin
      pp = pp & p[m];
    end
    lookahead = c | (pp & c0);
  endfunction

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
    localparam int LSB = gi * GROUP_W;
    localparam int GW  = ((SIZE - LSB) >= GROUP_W) ? GROUP_W : (SIZE - LSB);

    logic          cin;       // carry into this group
    logic          cout;      // carry out of this group
    logic          grp_gen;   // group generate
    logic          grp_prop;  // group propagate
    logic [3:0]    gl;        // group-local generate, zero-extended to 4
    logic [3:0]    pl;        // group-local propagate, zero-extended to 4
    logic [GW-1:0] cb;        // carry into each bit of the group

    // Group carries ripple from the previous group; group 0 takes Cin.
    if (gi == 0) begin : g_head
      assign cin = Cin;
    end else begin : g_link
      assign cin = g_group[gi-1].cout;
    end

    // Zero-extend a partial top group so the lookahead function sees a
    // fixed 4-bit slice; the padded bits are never selected by n < 4.
    always_comb begin
      gl         = '0;
      pl         = '0;
      gl[GW-1:0] = bit_gen[LSB +: GW];
      pl[GW-1:0] = bit_prop[LSB +: GW];
    end

    // Group G/P, group carry-out, and lookahead carries into every bit.
    always_comb begin
      grp_gen  = lookahead(gl, pl, 1'b0, GW);
      grp_prop = &pl[GW-1:0];
      cout     = grp_gen | (grp_prop & cin);
      cb       = '0;
      cb[0]    = cin;
      for (int j = 1; j < GW; j++) begin
        cb[j] = lookahead(gl, pl, cin, j);
      end
    end

    assign sum_comb[LSB +: GW] = pl[GW-1:0] ^ cb;
  end

  // Carry out of bit SIZE-1 is the carry out of the top group.
  assign carry_out = g_group[NGROUPS-1].cout;

  // Output registers: valid follows in_valid every cycle, data only loads
  // on a valid operation so idle inputs never disturb the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result    <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Result <= sum_comb;
        Cout   <= carry_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_custom_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_custom_adder_pipe
// Description : Self-checking bench for custom_adder_pipe (SIZE 32, 1, 7, 64)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_custom_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        cin;
  logic [63:0] a;
  logic [63:0] b;

  logic [31:0] res32;
  logic        cout32, ov32;
  logic [0:0]  res1;
  logic        cout1, ov1;
  logic [6:0]  res7;
  logic        cout7, ov7;
  logic [63:0] res64;
  logic        cout64, ov64;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboards: {carry, sum} pushed when an operation is driven.
  logic [64:0] q32[$];
  logic [64:0] q1[$];
  logic [64:0] q7[$];
  logic [64:0] q64[$];

  always #5 clk = ~clk;

  custom_adder_pipe #(.SIZE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a[31:0]), .B(b[31:0]),
    .Cin(cin), .Result(res32), .Cout(cout32), .out_valid(ov32));
  custom_adder_pipe #(.SIZE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a[0:0]), .B(b[0:0]),
    .Cin(cin), .Result(res1), .Cout(cout1), .out_valid(ov1));
  custom_adder_pipe #(.SIZE(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a[6:0]), .B(b[6:0]),
    .Cin(cin), .Result(res7), .Cout(cout7), .out_valid(ov7));
  custom_adder_pipe #(.SIZE(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b),
    .Cin(cin), .Result(res64), .Cout(cout64), .out_valid(ov64));

  // Reference: (n+1)-bit arithmetic sum of the low n bits of each operand.
  function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input int n);
    logic [64:0] mask;
    mask = (65'd1 << n) - 65'd1;
    ref_sum = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {64'd0, c};
  endfunction

  // Drive one cycle of stimulus at the falling edge; expected 32-bit result
  // is supplied by the caller and queued when the operation is valid.
  task automatic drive(input logic v, input logic [63:0] x, input logic [63:0] y,
                       input logic c, input logic [32:0] exp32);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    if (v) q32.push_back({32'd0, exp32});
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    a        = 64'hDEADBEEF_CAFEF00D;
    b        = 64'h01234567_89ABCDEF;
    cin      = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov32, cout32, res32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_immediate: got ov=%b cout=%b res=%h want 0/0/0", ov32, cout32, res32);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, cout32, res32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_held: got ov=%b cout=%b res=%h want 0/0/0", ov32, cout32, res32);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, cout32, res32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got ov=%b cout=%b res=%h want 0/0/0", ov32, cout32, res32);
    end
  endtask

  task automatic test_basic();
    logic [64:0] e;
    drive(1'b1, 64'h12345678, 64'h11111111, 1'b0, 33'h0_23456789);
    @(posedge clk);
    #1;
    n_checks++;
    if (ov32 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %b want 1", ov32);
    end
    n_checks++;
    if (q32.size() == 0) begin
      n_fail++;
      $display("FAIL basic_sum: scoreboard empty, got %h", {cout32, res32});
    end else begin
      e = q32.pop_front();
      if ({cout32, res32} !== e[32:0]) begin
        n_fail++;
        $display("FAIL basic_sum: got %h want %h", {cout32, res32}, e[32:0]);
      end
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 33'd0);
  endtask

  task automatic test_carry_chain();
    logic [63:0] ta[3];
    logic [63:0] tb[3];
    logic        tc[3];
    logic [32:0] te[3];
    logic [64:0] e;
    ta = '{64'hFFFFFFFF, 64'h80000000, 64'hFFFFFFFF};
    tb = '{64'h00000000, 64'h80000000, 64'hFFFFFFFF};
    tc = '{1'b1, 1'b1, 1'b1};
    te = '{33'h1_00000000, 33'h1_00000001, 33'h1_FFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ta[i], tb[i], tc[i], te[i]);
      @(posedge clk);
      #1;
      n_checks++;
      if (q32.size() == 0 || ov32 !== 1'b1) begin
        n_fail++;
        $display("FAIL carry_chain[%0d]: got ov=%b want 1 with queued result", i, ov32);
      end else begin
        e = q32.pop_front();
        if ({cout32, res32} !== e[32:0]) begin
          n_fail++;
          $display("FAIL carry_chain[%0d]: got %h want %h", i, {cout32, res32}, e[32:0]);
        end
      end
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 33'd0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ta[3];
    logic [63:0] tb[3];
    logic        tc[3];
    logic [32:0] te[3];
    logic [64:0] e;
    ta = '{64'd1, 64'd3, 64'h0000FFFF};
    tb = '{64'd2, 64'd4, 64'd1};
    tc = '{1'b0, 1'b1, 1'b0};
    te = '{33'd3, 33'd8, 33'h0_00010000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ta[i], tb[i], tc[i], te[i]);
      @(posedge clk);
      #1;
      n_checks++;
      if (q32.size() == 0 || ov32 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got ov=%b want 1 with queued result", i, ov32);
      end else begin
        e = q32.pop_front();
        if ({cout32, res32} !== e[32:0]) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got %h want %h", i, {cout32, res32}, e[32:0]);
        end
      end
    end
  endtask

  // Runs straight after test_back_to_back: idle cycles must hold 0x00010000.
  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 33'd0);
      @(posedge clk);
      #1;
      n_checks++;
      if ({ov32, cout32, res32} !== {1'b0, 33'h0_00010000}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ov=%b cout=%b res=%h want 0/0/00010000", i, ov32, cout32, res32);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, 64'h5, 64'h6, 1'b0, 33'd11);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    a        = 64'h77;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if ({ov32, cout32, res32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got ov=%b cout=%b res=%h want 0/0/0", ov32, cout32, res32);
    end
    q32.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, cout32, res32} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op_held: got ov=%b cout=%b res=%h want 0/0/0", ov32, cout32, res32);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (ov32 !== 1'b0 || res32 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op_release: got ov=%b res=%h want 0/0", ov32, res32);
    end
  endtask

  // Random operands on all four widths, one operation every cycle.
  task automatic test_random_sweep();
    logic [63:0] x;
    logic [63:0] y;
    logic        c;
    logic [64:0] e;
    q32.delete(); q1.delete(); q7.delete(); q64.delete();
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      if (i % 10 == 0) x = 64'hFFFFFFFF_FFFFFFFF ^ y;  // full-propagate patterns
      drive(1'b1, x, y, c, ref_sum(x, y, c, 32));
      q1.push_back(ref_sum(x, y, c, 1));
      q7.push_back(ref_sum(x, y, c, 7));
      q64.push_back(ref_sum(x, y, c, 64));
      @(posedge clk);
      #1;
      n_checks++;
      e = (q32.size() != 0) ? q32.pop_front() : 65'h1_FFFFFFFF_FFFFFFFF;
      if (ov32 !== 1'b1 || {cout32, res32} !== e[32:0]) begin
        n_fail++;
        $display("FAIL rand32[%0d]: got ov=%b %h want 1 %h", i, ov32, {cout32, res32}, e[32:0]);
      end
      n_checks++;
      e = (q1.size() != 0) ? q1.pop_front() : 65'h1_FFFFFFFF_FFFFFFFF;
      if (ov1 !== 1'b1 || {cout1, res1} !== e[1:0]) begin
        n_fail++;
        $display("FAIL rand1[%0d]: got ov=%b %h want 1 %h", i, ov1, {cout1, res1}, e[1:0]);
      end
      n_checks++;
      e = (q7.size() != 0) ? q7.pop_front() : 65'h1_FFFFFFFF_FFFFFFFF;
      if (ov7 !== 1'b1 || {cout7, res7} !== e[7:0]) begin
        n_fail++;
        $display("FAIL rand7[%0d]: got ov=%b %h want 1 %h", i, ov7, {cout7, res7}, e[7:0]);
      end
      n_checks++;
      e = (q64.size() != 0) ? q64.pop_front() : 65'h0_00000000_00000000;
      if (ov64 !== 1'b1 || {cout64, res64} !== e) begin
        n_fail++;
        $display("FAIL rand64[%0d]: got ov=%b %h want 1 %h", i, ov64, {cout64, res64}, e);
      end
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0, 33'd0);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_hold();
    test_reset_mid_op();
    test_random_sweep();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/custom_adder_pipe.md
Name: custom_adder_pipe

Overview:
- Parameterized SIZE-bit two's-complement/unsigned adder with carry-in and carry-out, registered at the output (one-cycle latency).
- Datapath building block for ALU/address-generation paths.
- Combinational core is a grouped carry-lookahead adder; the sum and carry are captured in output registers with a valid flag.
- Single clock domain; asynchronous active-low reset.

Parameters:
SIZE  32  operand and result width in bits; legal range 1..64

Ports:
clk       input   1     rising-edge clock
rst_n     input   1     asynchronous active-low reset
in_valid  input   1     A, B, Cin hold a valid operation this cycle
A         input   SIZE  operand A
B         input   SIZE  operand B
Cin       input   1     carry-in
Result    output  SIZE  registered sum, low SIZE bits of A+B+Cin
Cout      output  1     registered carry-out, bit SIZE of A+B+Cin
out_valid output  1     Result/Cout hold the result of a valid operation

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asserted asynchronously, independent of clk):
  - Result=0, Cout=0, out_valid=0 immediately.
  - Outputs hold these values while rst_n=0.
  - Release is synchronous in effect: the first capture happens at the first rising clk edge with rst_n=1.
- Arithmetic:
  - The full sum {Cout,Result} = A + B + Cin, computed in SIZE+1 bits.
  - Operands are treated as unsigned. The adder is sign-agnostic; no overflow flag is produced.
- Core structure:
  - Bit generate g=A&B, propagate p=A^B.
  - 4-bit carry-lookahead groups produce group G/P. Carries ripple between groups.
  - If SIZE is not a multiple of 4, the top group is partial.
  - Sum bit = p ^ carry-in of that bit. Cout = carry out of bit SIZE-1.
  - Result must equal the arithmetic sum for all inputs; the structure must not change function.
- Latency: exactly 1 cycle.
  - Inputs are sampled at rising edge N.
  - Result, Cout and out_valid update after edge N and are stable until edge N+1.
- Valid handling:
  - out_valid <= in_valid every cycle.
  - When in_valid=1: Result/Cout <= new sum/carry.
  - When in_valid=0: Result/Cout hold their previous values. No X propagates from idle inputs.
- Throughput: one operation per cycle. No backpressure and no stall input.
- Back-to-back valid inputs yield back-to-back valid outputs, in order.
- Wrap-around: carry out of the MSB goes only to Cout; Result wraps modulo 2^SIZE.
- Reset mid-operation: an operation sampled before reset is discarded. After reset, out_valid=0 until a new in_valid is captured.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst_n=0 asynchronously, mid-cycle with in_valid=1 -> Result=0x00000000, Cout=0, out_valid=0 immediately and while held low.
- Basic add: A=0x12345678, B=0x11111111, Cin=0, in_valid=1 -> next cycle Result=0x23456789, Cout=0, out_valid=1.
- Carry-in full propagation: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> Result=0x00000000, Cout=1.
- MSB wrap: A=0x80000000, B=0x80000000, Cin=1 -> Result=0x00000001, Cout=1. Then A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=1 -> Result=0xFFFFFFFF, Cout=1.
- Hold and pipeline:
  - Three back-to-back valid ops (1+2+0, 3+4+1, 0xFFFF+1+0) -> outputs 3, 8, 0x00010000 on consecutive cycles.
  - Then in_valid=0 with random A/B -> Result stays 0x00010000, out_valid=0.
- Random and parameter sweep:
  - 1000 random A/B/Cin with in_valid=1 -> each output matches a (SIZE+1)-bit reference sum one cycle later.
  - Repeat with SIZE=1, SIZE=7, SIZE=64.
